rf_xfer_ctrl: RTL and testbench
===============================

RF_XFER_CTRL -- requirements
Module: rf_xfer_ctrl

Interface
REQ-001 The block SHALL have no parameters; all datapaths are 8-bit and register addresses 3-bit, fixed.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  controller can accept a command.
REQ-006 cmd_op  input  2  opcode: 00 LDI, 01 MOV, 10 SWAP, 11 RD.
REQ-007 cmd_src  input  3  source register index.
REQ-008 cmd_dst  input  3  destination register index.
REQ-009 cmd_imm  input  8  immediate for LDI.
REQ-010 rf_load  output  1  register-file write enable.
REQ-011 rf_sel  output  3  register-file index, shared by read and write.
REQ-012 rf_d  output  8  register-file write data.
REQ-013 rf_q  input  8  register-file read data; combinational from rf_sel.
REQ-014 resp_valid  output  1  one-cycle completion pulse.
REQ-015 resp_data  output  8  result value, valid while resp_valid=1.
REQ-016 resp_err  output  1  readback mismatch flag, valid while resp_valid=1.

Function
REQ-017 States SHALL be IDLE, RD_A, RD_B, WR_A, WR_B, VF_A, VF_B, RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE; acceptance = cmd_valid & cmd_ready at a rising edge; op/src/dst/imm latched then.
REQ-019 cmd_valid outside IDLE SHALL be ignored; no queuing.
REQ-020 LDI: IDLE->WR_A (sel=dst, d=imm, load=1)->RESP; resp_data=imm.
REQ-021 MOV: IDLE->RD_A (sel=src, tmp_a<=rf_q)->WR_A (sel=dst, d=tmp_a, load=1)->RESP; resp_data=tmp_a.
REQ-022 SWAP: IDLE->RD_A (tmp_a<=reg[src])->RD_B (tmp_b<=reg[dst])->WR_A (reg[dst]<=tmp_a)->WR_B (reg[src]<=tmp_b)->RESP; resp_data=old reg[src].
REQ-023 RD: IDLE->RD_A (sel=src, tmp_a<=rf_q)->RESP; no write; resp_data=tmp_a.
REQ-024 rf_load SHALL be 1 only in WR_A/WR_B; rf_sel and rf_d SHALL be 0 in IDLE and RESP.
REQ-025 RESP SHALL last exactly one cycle with resp_valid=1, then IDLE unconditionally.
REQ-026 Latency, acceptance edge to resp_valid high (feature off): LDI 2, RD 2, MOV 3, SWAP 5 cycles.
REQ-027 src==dst: MOV and SWAP SHALL run the full sequence and leave the register value unchanged.
REQ-028 Minimum command spacing = latency + 1 cycle (the IDLE cycle).

Reset
REQ-029 reset=0 SHALL force IDLE immediately, asynchronously, from any state.
REQ-030 Reset values: cmd_ready=1 once reset deasserts, rf_load=0, rf_sel=0, rf_d=0, resp_valid=0, resp_data=0, resp_err=0, tmp_a=tmp_b=0.
REQ-031 Reset mid-SWAP SHALL abort without completion; writes already committed stay committed; no resp_valid.

Configuration
REQ-032 With RF_XFER_RDBK_EN defined, each write SHALL be followed by readback: after WR_A go to VF_A (sel=written index, compare rf_q with written data); SWAP also runs VF_B for src after WR_B; any mismatch sets resp_err=1 in RESP.
REQ-033 With RF_XFER_RDBK_EN defined, LDI and MOV latency SHALL be +1 cycle and SWAP +2; RD SHALL be unchanged.
REQ-034 Without RF_XFER_RDBK_EN, VF_A/VF_B SHALL be unreachable and resp_err SHALL be held at 0.

Verification
REQ-035 Reset, LDI dst=3 imm=0xA5 -> rf_load=1, rf_sel=3, rf_d=0xA5 for one cycle; resp_valid 2 cycles after acceptance with resp_data=0xA5.
REQ-036 reg1=0x11, reg6=0x66; SWAP src=1 dst=6 -> reg6=0x11, reg1=0x66; resp_data=0x11 at cycle 5.
REQ-037 MOV src=2 dst=2 with reg2=0x3C -> reg2 remains 0x3C; resp_data=0x3C at cycle 3.
REQ-038 cmd_valid held high with 2 commands queued externally -> second accepted only in the IDLE cycle after RESP; commands issued mid-operation are not accepted.
REQ-039 reset pulsed low during RD_B of SWAP -> outputs at reset values, no resp_valid, reg[src]/reg[dst] unchanged.
REQ-040 With RF_XFER_RDBK_EN defined and the register-file write forced to fail, LDI -> resp_err=1 at cycle 3; without the fault, resp_err=0.

Source files
------------

// File: rtl/rf_xfer_ctrl.sv
// Register-file transfer sequencer: LDI / MOV / SWAP / RD over a shared rf port.
// Optional readback verify after each write when RF_XFER_RDBK_EN is defined.
module rf_xfer_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_src,
  input  logic [2:0] cmd_dst,
  input  logic [7:0] cmd_imm,
  output logic       rf_load,
  output logic [2:0] rf_sel,
  output logic [7:0] rf_d,
  input  logic [7:0] rf_q,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_err
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, WR_A, WR_B, VF_A, VF_B, RESP
  } state_t;

  localparam logic [1:0] OP_LDI  = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_RD   = 2'b11;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] op_q;
  logic [2:0] src_q;
  logic [2:0] dst_q;
  logic [7:0] tmp_a;
  logic [7:0] tmp_b;
  logic       accept;

  assign accept = (state_q == IDLE) && cmd_valid;

  // State register plus command latch; LDI parks its immediate in tmp_a
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_LDI;
      src_q   <= '0;
      dst_q   <= '0;
      tmp_a   <= '0;
      tmp_b   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= cmd_op;
        src_q <= cmd_src;
        dst_q <= cmd_dst;
        if (cmd_op == OP_LDI)
          tmp_a <= cmd_imm;
      end
      if (state_q == RD_A)
        tmp_a <= rf_q;
      if (state_q == RD_B)
        tmp_b <= rf_q;
    end
  end

  // Next-state sequencing per opcode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid)
          state_d = (cmd_op == OP_LDI) ? WR_A : RD_A;
      end
      RD_A: begin
        unique case (op_q)
          OP_SWAP: state_d = RD_B;
          OP_RD:   state_d = RESP;
          default: state_d = WR_A;
        endcase
      end
      RD_B: state_d = WR_A;
      WR_A: begin
`ifdef RF_XFER_RDBK_EN
        state_d = VF_A;
`else
        state_d = (op_q == OP_SWAP) ? WR_B : RESP;
`endif
      end
      VF_A: state_d = (op_q == OP_SWAP) ? WR_B : RESP;
      WR_B: begin
`ifdef RF_XFER_RDBK_EN
        state_d = VF_B;
`else
        state_d = RESP;
`endif
      end
      VF_B: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register-file port and response outputs decoded from state
  always_comb begin
    cmd_ready  = 1'b0;
    rf_load    = 1'b0;
    rf_sel     = '0;
    rf_d       = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    unique case (state_q)
      IDLE: cmd_ready = 1'b1;
      RD_A: rf_sel = src_q;
      RD_B: rf_sel = dst_q;
      WR_A: begin
        rf_load = 1'b1;
        rf_sel  = dst_q;
        rf_d    = tmp_a;
      end
      WR_B: begin
        rf_load = 1'b1;
        rf_sel  = src_q;
        rf_d    = tmp_b;
      end
      VF_A: rf_sel = dst_q;
      VF_B: rf_sel = src_q;
      RESP: begin
        resp_valid = 1'b1;
        resp_data  = tmp_a;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

`ifdef RF_XFER_RDBK_EN
  logic err_q;

  // Sticky readback-mismatch flag, cleared when a new command is taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_q <= 1'b0;
    else if (accept)
      err_q <= 1'b0;
    else if ((state_q == VF_A) && (rf_q != tmp_a))
      err_q <= 1'b1;
    else if ((state_q == VF_B) && (rf_q != tmp_b))
      err_q <= 1'b1;
  end

  assign resp_err = (state_q == RESP) && err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_rf_xfer_ctrl.sv
// Bench for rf_xfer_ctrl: external register file, transaction-level model,
// per-cycle compare process and directed literal checks.
module tb_rf_xfer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_src;
  logic [2:0] cmd_dst;
  logic [7:0] cmd_imm;
  logic       rf_load;
  logic [2:0] rf_sel;
  logic [7:0] rf_d;
  logic [7:0] rf_q;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_err;

  localparam logic [1:0] LDI = 2'b00;
  localparam logic [1:0] MOV = 2'b01;
  localparam logic [1:0] SWP = 2'b10;
  localparam logic [1:0] RD  = 2'b11;

`ifdef RF_XFER_RDBK_EN
  localparam int LAT_LDI  = 3;
  localparam int LAT_MOV  = 4;
  localparam int LAT_SWAP = 7;
`else
  localparam int LAT_LDI  = 2;
  localparam int LAT_MOV  = 3;
  localparam int LAT_SWAP = 5;
`endif
  localparam int LAT_RD = 2;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc[$];
  logic run_chk = 1'b0;
  logic wr_fail = 1'b0;

  always #5 clk = ~clk;

  rf_xfer_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_imm    (cmd_imm),
    .rf_load    (rf_load),
    .rf_sel     (rf_sel),
    .rf_d       (rf_d),
    .rf_q       (rf_q),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  // External register file (not reset); wr_fail drops writes
  logic [7:0] rf [8] = '{default: 8'h00};
  always @(posedge clk)
    if (rf_load && !wr_fail)
      rf[rf_sel] <= rf_d;
  assign rf_q = rf[rf_sel];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Transaction model: busy counts cycles left until back to idle
  int         busy = 0;
  logic [7:0] m_rf [8] = '{default: 8'h00};
  logic [1:0] p_op;
  logic [2:0] p_src;
  logic [2:0] p_dst;
  logic [7:0] p_imm;
  logic       p_fail;
  logic       pend = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_err = 1'b0;

  always @(posedge clk or negedge reset) begin
    logic [7:0] t;
    if (!reset) begin
      busy = 0;
      pend = 1'b0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0 && pend) begin
        pend = 1'b0;
        if (!p_fail) begin
          case (p_op)
            LDI: m_rf[p_dst] = p_imm;
            MOV: m_rf[p_dst] = m_rf[p_src];
            SWP: begin
              t = m_rf[p_src];
              m_rf[p_src] = m_rf[p_dst];
              m_rf[p_dst] = t;
            end
            default: ;
          endcase
        end
      end
    end else if (cmd_valid) begin
      p_op = cmd_op;
      p_src = cmd_src;
      p_dst = cmd_dst;
      p_imm = cmd_imm;
      p_fail = wr_fail;
      pend = 1'b1;
      exp_err = wr_fail;
      exp_data = (cmd_op == LDI) ? cmd_imm : m_rf[cmd_src];
      case (cmd_op)
        LDI: busy = LAT_LDI;
        MOV: busy = LAT_MOV;
        SWP: busy = LAT_SWAP;
        default: busy = LAT_RD;
      endcase
    end
  end

  // Cycle counter and log of cycles where the DUT took a command
  always @(posedge clk) begin
    cyc++;
    if (reset && cmd_valid && cmd_ready)
      acc_cyc.push_back(cyc);
  end

  // Per-cycle compare of DUT against the model
  always @(negedge clk) begin
    logic same;
    if (reset && run_chk) begin
      chk("cmd_ready", cmd_ready, busy == 0);
      chk("resp_valid", resp_valid, busy == 1);
      if (busy == 1) begin
        chk("resp_data", resp_data, exp_data);
        chk("resp_err", resp_err, exp_err);
      end
      if (busy == 0) begin
        chk("rf_load_idle", rf_load, 0);
        chk("rf_sel_idle", rf_sel, 0);
        chk("rf_d_idle", rf_d, 0);
        same = 1'b1;
        for (int i = 0; i < 8; i++)
          if (rf[i] !== m_rf[i]) same = 1'b0;
        chk("rf_contents", same, 1);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] src,
                      input logic [2:0] dst, input logic [7:0] imm);
    int n;
    @(posedge clk);
    #2;
    cmd_op = op;
    cmd_src = src;
    cmd_dst = dst;
    cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!cmd_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy != 0) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_src = '0;
    cmd_dst = '0;
    cmd_imm = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rf_load", rf_load, 0);
    chk("rst_rf_sel", rf_sel, 0);
    chk("rst_rf_d", rf_d, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    reset = 1'b1;
    run_chk = 1'b1;

    send(LDI, 3'd0, 3'd3, 8'hA5);
    @(negedge clk);
    chk("ldi_wr_load", rf_load, 1);
    chk("ldi_wr_sel", rf_sel, 3);
    chk("ldi_wr_d", rf_d, 8'hA5);
    repeat (LAT_LDI - 1) @(negedge clk);
    chk("ldi_resp_valid", resp_valid, 1);
    chk("ldi_resp_data", resp_data, 8'hA5);
    wait_idle();

    send(LDI, 3'd0, 3'd1, 8'h11); wait_idle();
    send(LDI, 3'd0, 3'd6, 8'h66); wait_idle();
    send(LDI, 3'd0, 3'd2, 8'h3C); wait_idle();

    send(SWP, 3'd1, 3'd6, 8'h00);
    repeat (LAT_SWAP) @(negedge clk);
    chk("swap_resp_valid", resp_valid, 1);
    chk("swap_resp_data", resp_data, 8'h11);
    wait_idle();
    chk("swap_reg6", rf[6], 8'h11);
    chk("swap_reg1", rf[1], 8'h66);

    send(MOV, 3'd2, 3'd2, 8'h00);
    repeat (LAT_MOV) @(negedge clk);
    chk("mov_same_resp_valid", resp_valid, 1);
    chk("mov_same_resp_data", resp_data, 8'h3C);
    wait_idle();
    chk("mov_same_reg2", rf[2], 8'h3C);

    send(RD, 3'd6, 3'd0, 8'h00);
    repeat (LAT_RD) @(negedge clk);
    chk("rd_resp_valid", resp_valid, 1);
    chk("rd_resp_data", resp_data, 8'h11);
    wait_idle();

    send(MOV, 3'd6, 3'd0, 8'h00); wait_idle();
    chk("mov_reg0", rf[0], 8'h11);

    send(SWP, 3'd3, 3'd3, 8'h00); wait_idle();
    chk("swap_same_reg3", rf[3], 8'hA5);

    acc_cyc.delete();
    @(posedge clk);
    #2;
    cmd_op = LDI; cmd_dst = 3'd7; cmd_imm = 8'h5A;
    cmd_valid = 1'b1;
    n = 0;
    while (acc_cyc.size() < 1 && n < 50) begin
      @(posedge clk); #2; n++;
    end
    cmd_op = LDI; cmd_dst = 3'd4; cmd_imm = 8'hC3;
    while (acc_cyc.size() < 2 && n < 50) begin
      @(posedge clk); #2; n++;
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2)
      chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], LAT_LDI + 1);
    wait_idle();
    chk("b2b_reg7", rf[7], 8'h5A);
    chk("b2b_reg4", rf[4], 8'hC3);

    send(SWP, 3'd7, 3'd4, 8'h00);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_rf_load", rf_load, 0);
    chk("abort_rf_sel", rf_sel, 0);
    chk("abort_rf_d", rf_d, 0);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_resp_data", resp_data, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_reg7", rf[7], 8'h5A);
    chk("abort_reg4", rf[4], 8'hC3);

    send(LDI, 3'd0, 3'd5, 8'h42);
    repeat (LAT_LDI) @(negedge clk);
    chk("post_rst_resp_data", resp_data, 8'h42);
    wait_idle();

`ifdef RF_XFER_RDBK_EN
    wr_fail = 1'b1;
    send(LDI, 3'd0, 3'd5, 8'h77);
    repeat (LAT_LDI) @(negedge clk);
    chk("rdbk_fault_err", resp_err, 1);
    wait_idle();
    wr_fail = 1'b0;
    send(LDI, 3'd0, 3'd5, 8'h78);
    repeat (LAT_LDI) @(negedge clk);
    chk("rdbk_ok_err", resp_err, 0);
    wait_idle();
`endif

    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
